// File: rtl/insertion_sorter.sv
// insertion_sorter: in-place insertion sort of an external memory holding
// locations 0..arr_size-1. The memory has a one-cycle read latency.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, desc       start a sort (IDLE only); desc=1 sorts descending
//   arr_size          element count, clamped to 2^ADDR_WDTH
//   ar_en/ar_address  read request; r_data is valid one cycle after ar_en
//   write_en/_addr/_data  write strobe, address and data
//   busy, done        sort in progress / one-cycle completion pulse
//   shift_count       number of SHIFT writes in the current or last sort
module insertion_sorter #(
    parameter int unsigned ADDR_WDTH  = 4,
    parameter int unsigned DATA_WDTH  = 32,
    parameter int unsigned SIGNED_CMP = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   desc,
    input  logic [ADDR_WDTH:0]     arr_size,
    output logic                   ar_en,
    output logic [ADDR_WDTH-1:0]   ar_address,
    input  logic [DATA_WDTH-1:0]   r_data,
    output logic                   write_en,
    output logic [ADDR_WDTH-1:0]   write_addr,
    output logic [DATA_WDTH-1:0]   write_data,
    output logic                   busy,
    output logic                   done,
    output logic [2*ADDR_WDTH:0]   shift_count
);

    localparam int unsigned IW = ADDR_WDTH + 1;
    localparam int unsigned CW = 2 * ADDR_WDTH + 1;
    localparam logic [IW-1:0] MAX_N = IW'(1) << ADDR_WDTH;

    typedef enum logic [2:0] {
        IDLE, RD_KEY, WT_KEY, RD_CMP, WT_CMP, SHIFT, INSERT, DONE
    } state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          size_q, size_n;
    logic                   desc_q, desc_n;
    logic [IW-1:0]          i_q, i_n;
    // j counts down to -1 (all ones); j+1 then wraps back to address 0
    logic [IW-1:0]          j_q, j_n;
    logic [DATA_WDTH-1:0]   key_q, key_n;
    logic [DATA_WDTH-1:0]   cmp_q, cmp_n;
    logic [CW-1:0]          cnt_n;
    logic [IW-1:0]          clamp;
    logic                   gt, lt, out_of_order;

    logic                   ar_en_n, write_en_n, busy_n, done_n;
    logic [ADDR_WDTH-1:0]   ar_address_n, write_addr_n;
    logic [DATA_WDTH-1:0]   write_data_n;

    // Strict compare of the freshly read element against the key
    always_comb begin
        if (SIGNED_CMP != 0) begin
            gt = $signed(r_data) > $signed(key_q);
            lt = $signed(r_data) < $signed(key_q);
        end else begin
            gt = r_data > key_q;
            lt = r_data < key_q;
        end
        out_of_order = desc_q ? lt : gt;
    end

    // Next-state logic; outputs are derived from the next state so that they
    // come straight from flops and line up with the state they belong to
    always_comb begin
        state_n = state;
        size_n  = size_q;
        desc_n  = desc_q;
        i_n     = i_q;
        j_n     = j_q;
        key_n   = key_q;
        cmp_n   = cmp_q;
        cnt_n   = shift_count;
        clamp   = (arr_size > MAX_N) ? MAX_N : arr_size;

        case (state)
            IDLE: begin
                if (start) begin
                    desc_n = desc;
                    size_n = clamp;
                    cnt_n  = '0;
                    if (clamp < IW'(2)) begin
                        state_n = DONE;
                    end else begin
                        i_n     = IW'(1);
                        state_n = RD_KEY;
                    end
                end
            end
            RD_KEY: state_n = WT_KEY;
            WT_KEY: begin
                key_n   = r_data;
                j_n     = i_q - IW'(1);
                state_n = RD_CMP;
            end
            RD_CMP: state_n = WT_CMP;
            WT_CMP: begin
                cmp_n   = r_data;
                state_n = out_of_order ? SHIFT : INSERT;
            end
            SHIFT: begin
                cnt_n   = shift_count + CW'(1);
                j_n     = j_q - IW'(1);
                state_n = (j_q == '0) ? INSERT : RD_CMP;
            end
            INSERT: begin
                if (i_q + IW'(1) == size_q) begin
                    state_n = DONE;
                end else begin
                    i_n     = i_q + IW'(1);
                    state_n = RD_KEY;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        ar_en_n      = (state_n == RD_KEY) || (state_n == RD_CMP);
        write_en_n   = (state_n == SHIFT) || (state_n == INSERT);
        busy_n       = (state_n != IDLE);
        done_n       = (state_n == DONE);
        ar_address_n = '0;
        write_addr_n = '0;
        write_data_n = '0;
        if (state_n == RD_KEY) ar_address_n = ADDR_WDTH'(i_n);
        if (state_n == RD_CMP) ar_address_n = ADDR_WDTH'(j_n);
        if (write_en_n)        write_addr_n = ADDR_WDTH'(j_n + IW'(1));
        if (state_n == SHIFT)  write_data_n = cmp_n;
        if (state_n == INSERT) write_data_n = key_n;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            size_q      <= '0;
            desc_q      <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            key_q       <= '0;
            cmp_q       <= '0;
            shift_count <= '0;
            ar_en       <= 1'b0;
            ar_address  <= '0;
            write_en    <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            size_q      <= size_n;
            desc_q      <= desc_n;
            i_q         <= i_n;
            j_q         <= j_n;
            key_q       <= key_n;
            cmp_q       <= cmp_n;
            shift_count <= cnt_n;
            ar_en       <= ar_en_n;
            ar_address  <= ar_address_n;
            write_en    <= write_en_n;
            write_addr  <= write_addr_n;
            write_data  <= write_data_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule
